// File: rtl/vid_mem_arbiter_pkg.sv
// Shared display types for the frame-buffer arbiter and its write FIFO.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package vid_mem_arbiter_pkg;

    localparam int VID_ADDR_W = 19;
    localparam int VID_DATA_W = 9;

    typedef logic [VID_ADDR_W-1:0] VidAddr_t;
    typedef logic [VID_DATA_W-1:0] VidData_t;

    // One queued renderer write: address in the upper bits, pixel below.
    typedef struct packed {
        VidAddr_t addr;
        VidData_t data;
    } VidWrEntry_t;

    typedef enum logic {
        ARB_NORMAL   = 1'b0,
        ARB_FORCE_WR = 1'b1
    } ArbState_t;

    // Saturating 16-bit increment for the optional statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vid_wr_fifo.sv
// Synchronous FIFO of renderer write entries; head is visible combinationally.
// Latency: a push is visible at the head one edge later; level is registered.
// Backpressure: push ignored when full, pop ignored when empty.
module vid_wr_fifo
    import vid_mem_arbiter_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  VidWrEntry_t       push_dat,
    input  logic              pop,
    output VidWrEntry_t       head,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    VidWrEntry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr];

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vid_mem_arbiter.sv
// Frame-buffer RAM arbiter: scan-out reads win, renderer writes queue in a FIFO.
// Latency: read grant -> rd_valid 3 cycles; write grant -> mem_we 1 cycle.
// Backpressure: rd_ready drops only in a forced write slot; wr_ready = FIFO not full.
// Optional statistics counters are built when VIDARB_STATS_EN is defined.
module vid_mem_arbiter
    import vid_mem_arbiter_pkg::*;
#(
    parameter  int ADDR_W        = VID_ADDR_W,
    parameter  int DATA_W        = VID_DATA_W,
    parameter  int FIFO_DEPTH    = 8,
    parameter  int WR_STARVE_MAX = 16,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow
`ifdef VIDARB_STATS_EN
    ,
    output logic [15:0]       stat_rd_stall,
    output logic [15:0]       stat_forced_wr
`endif
);

    // Counter only has to reach WR_STARVE_MAX-1.
    localparam int CNT_W = (WR_STARVE_MAX > 1) ? $clog2(WR_STARVE_MAX) : 1;

    ArbState_t         state_q;
    logic [CNT_W-1:0]  starve_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    VidWrEntry_t       fifo_head;
    VidWrEntry_t       push_dat;
    logic              push;
    logic              force_grant;
    logic              rd_grant;
    logic              wr_grant;
    logic              rd_s1;
    logic              rd_s2;

    // Ready outputs are held low while reset is asserted.
    assign rd_ready = rst && !force_grant;
    assign wr_ready = rst && !fifo_full;
    assign push     = wr_req && wr_ready;
    assign push_dat = '{addr: wr_addr, data: wr_data};

    // Per-cycle grant from registered state: forced write, then read, then queued write.
    always_comb begin
        force_grant = (state_q == ARB_FORCE_WR) && !fifo_empty;
        rd_grant    = rd_req && !force_grant;
        wr_grant    = !fifo_empty && (force_grant || !rd_req);
    end

    vid_wr_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (wr_grant),
        .head     (fifo_head),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Starvation tracking: count reads that bypassed a waiting write, then force one slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_NORMAL;
            starve_cnt <= '0;
        end else if (state_q == ARB_FORCE_WR) begin
            state_q    <= ARB_NORMAL;
            starve_cnt <= '0;
        end else if (rd_grant && !fifo_empty) begin
            if (starve_cnt == CNT_W'(WR_STARVE_MAX - 1)) begin
                state_q    <= ARB_FORCE_WR;
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Registered RAM port; address holds when idle so the RAM sees no spurious toggles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else if (wr_grant) begin
            mem_addr  <= fifo_head.addr;
            mem_wdata <= fifo_head.data;
            mem_we    <= 1'b1;
        end else if (rd_grant) begin
            mem_addr  <= rd_addr;
            mem_we    <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
        end
    end

    // Read tag: stage 1 = address on RAM, stage 2 = RAM data valid, then register out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_s1    <= 1'b0;
            rd_s2    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_s1    <= rd_grant;
            rd_s2    <= rd_s1;
            rd_valid <= rd_s2;
            if (rd_s2) begin
                rd_data <= mem_rdata;
            end
        end
    end

    // Sticky flag for a write offered while the FIFO was full; that write is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (wr_req && !wr_ready) begin
            overflow <= 1'b1;
        end
    end

`ifdef VIDARB_STATS_EN
    // Saturating counters of stalled read cycles and forced write slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rd_stall  <= '0;
            stat_forced_wr <= '0;
        end else begin
            if (rd_req && !rd_ready) begin
                stat_rd_stall <= sat_inc16(stat_rd_stall);
            end
            if (force_grant) begin
                stat_forced_wr <= sat_inc16(stat_forced_wr);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Randomised bench for vid_mem_arbiter against a queue-based reference model.
// Latency: model predicts mem_we one cycle and rd_valid three cycles after grant.
// Backpressure: model tracks FIFO occupancy, drops and forced write slots.
module tb_vid_mem_arbiter;

    localparam int DEPTH  = 8;
    localparam int STARVE = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0;
    logic [18:0] rd_addr = '0;
    logic        rd_ready;
    logic        rd_valid;
    logic [8:0]  rd_data;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [8:0]  wr_data = '0;
    logic        wr_ready;
    logic [18:0] mem_addr;
    logic [8:0]  mem_wdata;
    logic        mem_we;
    logic [8:0]  mem_rdata = '0;
    logic [3:0]  fifo_level;
    logic        overflow;
`ifdef VIDARB_STATS_EN
    logic [15:0] stat_rd_stall;
    logic [15:0] stat_forced_wr;
`endif

    vid_mem_arbiter #(
        .ADDR_W        (19),
        .DATA_W        (9),
        .FIFO_DEPTH    (DEPTH),
        .WR_STARVE_MAX (STARVE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef VIDARB_STATS_EN
        ,
        .stat_rd_stall  (stat_rd_stall),
        .stat_forced_wr (stat_forced_wr)
`endif
    );

    always #5 clk = ~clk;

    // Frame-buffer RAM model: 256 words aliased on the low address byte, 1-cycle read.
    logic [8:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    // Reference model state.
    typedef struct {
        int         due;
        logic [8:0] d;
    } rexp_t;

    logic [27:0] mq [$];
    rexp_t       rxq [$];
    logic [8:0]  mram [256];
    logic        e_we;
    logic [18:0] e_addr;
    logic [8:0]  e_wdata;
    logic        e_ovf;
    logic        m_force;
    int          m_starve;
    int          m_stall;
    int          m_forced;

    int cyc        = 0;
    int n_checks   = 0;
    int n_fail     = 0;
    int n_we_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        rxq.delete();
        e_we     = 1'b0;
        e_addr   = '0;
        e_wdata  = '0;
        e_ovf    = 1'b0;
        m_force  = 1'b0;
        m_starve = 0;
        m_stall  = 0;
        m_forced = 0;
    endtask

    // One clock: check outputs from the last edge, drive new inputs, advance the model.
    task automatic step(input logic rq, input logic [18:0] ra,
                        input logic wq, input logic [18:0] wa, input logic [8:0] wd);
        int          sz;
        logic        ne;
        logic        rg;
        logic        wg;
        logic [27:0] ent;
        rexp_t       t;
        @(negedge clk);
        cyc++;
        sz = mq.size();
        chk("rd_ready", rd_ready, !(m_force && sz > 0));
        chk("wr_ready", wr_ready, sz != DEPTH);
        chk("fifo_level", fifo_level, sz);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        if (mem_we === 1'b1) n_we_seen++;
        if (rxq.size() > 0 && rxq[0].due == cyc) begin
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, rxq[0].d);
            void'(rxq.pop_front());
        end else begin
            chk("rd_valid", rd_valid, 0);
        end
        chk("overflow", overflow, e_ovf);
`ifdef VIDARB_STATS_EN
        chk("stat_rd_stall", stat_rd_stall, m_stall);
        chk("stat_forced_wr", stat_forced_wr, m_forced);
`endif
        rd_req  = rq;
        rd_addr = ra;
        wr_req  = wq;
        wr_addr = wa;
        wr_data = wd;
        // Last cycle's write has now landed in RAM.
        if (e_we) mram[e_addr[7:0]] = e_wdata;
        ne = (sz > 0);
        rg = 1'b0;
        wg = 1'b0;
        if (m_force && ne) begin
            wg = 1'b1;
            m_forced++;
        end else if (rq) begin
            rg = 1'b1;
        end else if (ne) begin
            wg = 1'b1;
        end
        if (rq && !rg) m_stall++;
        // Consecutive reads granted past a waiting write earn the write one slot.
        if (m_force) begin
            m_force  = 1'b0;
            m_starve = 0;
        end else if (ne && rg) begin
            m_starve++;
            if (m_starve == STARVE) begin
                m_force  = 1'b1;
                m_starve = 0;
            end
        end else begin
            m_starve = 0;
        end
        e_we = 1'b0;
        if (wg) begin
            ent     = mq.pop_front();
            e_we    = 1'b1;
            e_addr  = ent[27:9];
            e_wdata = ent[8:0];
        end else if (rg) begin
            e_addr = ra;
            t.due  = cyc + 3;
            t.d    = mram[ra[7:0]];
            rxq.push_back(t);
        end
        if (wq) begin
            if (sz != DEPTH) mq.push_back({wa, wd});
            else e_ovf = 1'b1;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must drop at once.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst    = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        #1;
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("wr_ready_after_rst", wr_ready, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 9'(i);
            mram[i] = 9'(i);
        end
        model_clear();
        do_reset();

        // Single write with no reads: reaches RAM two cycles after acceptance.
        step(1'b0, '0, 1'b1, 19'h00010, 9'h1A5);
        idle(4);

        // Back-to-back reads of 0..7 against data = address.
        for (int i = 0; i < 8; i++) step(1'b1, 19'(i), 1'b0, '0, '0);
        idle(5);

        // Continuous reads with three writes queued: forced write slots.
        do_reset();
        n_we_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 19'(i + 32), 1'b1, 19'(i + 200), 9'(i + 9'h40));
        for (int i = 0; i < 60; i++) step(1'b1, 19'(i), 1'b0, '0, '0);
        chk("starve_writes_done", n_we_seen, 3);
        idle(4);

        // Nine pushes into an 8-deep FIFO while reads hold the RAM.
        do_reset();
        n_we_seen = 0;
        for (int i = 0; i < 9; i++) step(1'b1, 19'(i), 1'b1, 19'(i + 100), 9'(i + 9'h80));
        for (int i = 0; i < 20; i++) step(1'b1, 19'(i), 1'b0, '0, '0);
        idle(15);
        chk("overflow_writes_done", n_we_seen, 8);
        chk("overflow_sticky", overflow, 1);

        // Reset with reads and writes in flight; nothing may emerge afterwards.
        step(1'b1, 19'd5, 1'b1, 19'd50, 9'h11);
        step(1'b1, 19'd6, 1'b1, 19'd51, 9'h12);
        step(1'b0, '0, 1'b1, 19'd52, 9'h13);
        step(1'b0, '0, 1'b1, 19'd53, 9'h14);
        do_reset();
        n_we_seen = 0;
        idle(6);
        chk("post_rst_no_we", n_we_seen, 0);

        // Randomised traffic at several read/write densities.
        for (int seg = 0; seg < 4; seg++) begin
            int prd;
            int pwr;
            prd = 20 + seg * 25;
            pwr = 70 - seg * 15;
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(0, 99) < prd, 19'($urandom),
                     $urandom_range(0, 99) < pwr, 19'($urandom), 9'($urandom));
            end
            if (seg == 1) do_reset();
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
